// File: rtl/round_judge_if.sv
// round_judge_if: quiz-round bundle between the round driver and round_judge.
// Carries START/KEY, both players' answer strobes, and the judged outputs.
interface round_judge_if #(
  parameter int unsigned W  = 8,
  parameter int unsigned TW = 12
);
  logic          START;
  logic [W-1:0]  KEY;
  logic [W-1:0]  MY_ANS;
  logic          MY_VLD;
  logic [W-1:0]  EN_ANS;
  logic          EN_VLD;
  logic [1:0]    RESULT;
  logic          ROUND_ACT;
  logic          MY_LOCK;
  logic          EN_LOCK;
  logic [TW-1:0] TIME_LEFT;

  modport master (
    output START, KEY, MY_ANS, MY_VLD,
    output EN_ANS, EN_VLD,
    input  RESULT, ROUND_ACT,
    input  MY_LOCK, EN_LOCK, TIME_LEFT
  );

  modport slave (
    input  START, KEY, MY_ANS, MY_VLD,
    input  EN_ANS, EN_VLD,
    output RESULT, ROUND_ACT,
    output MY_LOCK, EN_LOCK, TIME_LEFT
  );
endinterface

// File: rtl/round_judge.sv
// round_judge: judges one quiz round, emits a held 2-bit result code.
// Ports: CLK, RST (async low), bus (slave: START/KEY/answers in, RESULT/locks/timer out).
module round_judge #(
  parameter int unsigned    W       = 8,
  parameter int unsigned    TW      = 12,
  parameter logic [TW-1:0]  TIMEOUT = 12'd2000,
  parameter int unsigned    HOLD    = 4
) (
  input  logic        CLK,
  input  logic        RST,
  round_judge_if.slave bus
);

  localparam int unsigned HW = $clog2(HOLD + 1);

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    REPORT
  } state_t;

  state_t        state_q;
  logic [W-1:0]  key_q;
  logic [1:0]    result_q;
  logic          act_q;
  logic          my_lock_q;
  logic          en_lock_q;
  logic [TW-1:0] time_q;
  logic [HW-1:0] hold_q;

  logic       my_ok, my_bad;
  logic       en_ok, en_bad;
  logic [1:0] code;

  always_comb begin
    my_ok  = bus.MY_VLD & ~my_lock_q
           & (bus.MY_ANS == key_q);
    my_bad = bus.MY_VLD & ~my_lock_q
           & (bus.MY_ANS != key_q);
    en_ok  = bus.EN_VLD & ~en_lock_q
           & (bus.EN_ANS == key_q);
    en_bad = bus.EN_VLD & ~en_lock_q
           & (bus.EN_ANS != key_q);
  end

  // Priority order matters: a correct answer wins
  // over a wrong one and over the timeout.
  always_comb begin
    code = 2'b00;
    if (my_ok && en_ok)
      code = 2'b11;
    else if (my_ok)
      code = 2'b01;
    else if (en_ok)
      code = 2'b10;
    else if ((my_lock_q | my_bad) &&
             (en_lock_q | en_bad))
      code = 2'b11;
    else if (time_q == '0)
      code = 2'b11;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= IDLE;
      key_q     <= '0;
      result_q  <= 2'b00;
      act_q     <= 1'b0;
      my_lock_q <= 1'b0;
      en_lock_q <= 1'b0;
      time_q    <= '0;
      hold_q    <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          result_q <= 2'b00;
          if (bus.START) begin
            key_q     <= bus.KEY;
            time_q    <= TIMEOUT;
            my_lock_q <= 1'b0;
            en_lock_q <= 1'b0;
            act_q     <= 1'b1;
            state_q   <= ARMED;
          end
        end
        ARMED: begin
          if (code != 2'b00) begin
            result_q <= code;
            hold_q   <= HW'(HOLD);
            act_q    <= 1'b0;
            state_q  <= REPORT;
          end else begin
            if (my_bad) my_lock_q <= 1'b1;
            if (en_bad) en_lock_q <= 1'b1;
            if (time_q != '0)
              time_q <= time_q - TW'(1);
          end
        end
        REPORT: begin
          // Returning through IDLE guarantees a 00
          // gap before the next code.
          if (hold_q <= HW'(1)) begin
            result_q <= 2'b00;
            state_q  <= IDLE;
          end else begin
            hold_q <= hold_q - HW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.RESULT    = result_q;
  assign bus.ROUND_ACT = act_q;
  assign bus.MY_LOCK   = my_lock_q;
  assign bus.EN_LOCK   = en_lock_q;
  assign bus.TIME_LEFT = time_q;

endmodule

// File: tb/tb_round_judge.sv
// tb_round_judge: random and directed rounds for round_judge,
// checked against a round-level reference model.
module tb_round_judge;

  localparam int TO   = 10;
  localparam int HOLD = 4;

  logic CLK;
  logic RST;

  round_judge_if #(.W(8), .TW(12)) bus ();

  round_judge #(
    .W(8), .TW(12),
    .TIMEOUT(12'd10), .HOLD(4)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_cmp;
  int n_bad;

  logic [7:0] key;
  logic [7:0] my_a [0:TO];
  logic [7:0] en_a [0:TO];
  bit         my_v [0:TO];
  bit         en_v [0:TO];
  bit         mlk  [0:TO];
  bit         elk  [0:TO];
  int         d;
  logic [1:0] code;

  task automatic check(string tag,
                       logic [31:0] got,
                       logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h",
               tag, got, exp);
    end
  endtask

  task automatic clear_stim();
    for (int k = 0; k <= TO; k++) begin
      my_v[k] = 1'b0;
      en_v[k] = 1'b0;
      my_a[k] = 8'($urandom);
      en_a[k] = 8'($urandom);
    end
  endtask

  // Round-level model: a player is locked at cycle k
  // if any earlier strobe of theirs was wrong; the
  // round ends at the first cycle with a verdict.
  task automatic model_round();
    bit ml, el, mok, eok, mbad, ebad;
    d    = -1;
    code = 2'b00;
    for (int k = 0; k <= TO; k++) begin
      ml = 1'b0;
      el = 1'b0;
      for (int j = 0; j < k; j++) begin
        if (my_v[j] && my_a[j] != key) ml = 1'b1;
        if (en_v[j] && en_a[j] != key) el = 1'b1;
      end
      mlk[k] = ml;
      elk[k] = el;
      if (d < 0) begin
        mok  = my_v[k] && !ml && my_a[k] == key;
        eok  = en_v[k] && !el && en_a[k] == key;
        mbad = my_v[k] && !ml && my_a[k] != key;
        ebad = en_v[k] && !el && en_a[k] != key;
        if (mok && eok) code = 2'b11;
        else if (mok) code = 2'b01;
        else if (eok) code = 2'b10;
        else if ((ml || mbad) && (el || ebad))
          code = 2'b11;
        else if (k == TO) code = 2'b11;
        if (code != 2'b00) d = k;
      end
    end
  endtask

  task automatic drive(int k);
    bus.MY_VLD = my_v[k];
    bus.MY_ANS = my_a[k];
    bus.EN_VLD = en_v[k];
    bus.EN_ANS = en_a[k];
    bus.START  = 1'($urandom);
    bus.KEY    = 8'($urandom);
  endtask

  task automatic idle_in();
    bus.START  = 1'b0;
    bus.MY_VLD = 1'b0;
    bus.EN_VLD = 1'b0;
  endtask

  task automatic chk_state(string tg, bit act,
                           logic [1:0] res, int tl,
                           bit ml, bit el);
    check({tg, ".act"}, 32'(bus.ROUND_ACT), 32'(act));
    check({tg, ".res"}, 32'(bus.RESULT), 32'(res));
    check({tg, ".time"}, 32'(bus.TIME_LEFT), 32'(tl));
    check({tg, ".mlk"}, 32'(bus.MY_LOCK), 32'(ml));
    check({tg, ".elk"}, 32'(bus.EN_LOCK), 32'(el));
  endtask

  task automatic run_round(string tg);
    model_round();
    @(negedge CLK);
    idle_in();
    bus.START = 1'b1;
    bus.KEY   = key;
    @(negedge CLK);
    chk_state({tg, ".arm"}, 1, 2'b00, TO, 0, 0);
    for (int k = 0; k <= d; k++) begin
      drive(k);
      @(negedge CLK);
      if (k < d)
        chk_state({tg, ".run"}, 1, 2'b00,
                  TO - k - 1, mlk[k+1], elk[k+1]);
      else
        chk_state({tg, ".hit"}, 0, code,
                  TO - d, mlk[d], elk[d]);
    end
    for (int h = 1; h <= HOLD; h++) begin
      bus.START  = 1'($urandom);
      bus.MY_VLD = 1'($urandom);
      bus.EN_VLD = 1'($urandom);
      bus.MY_ANS = key;
      bus.EN_ANS = key;
      @(negedge CLK);
      chk_state({tg, ".rep"}, 0,
                (h < HOLD) ? code : 2'b00,
                TO - d, mlk[d], elk[d]);
    end
    idle_in();
    @(negedge CLK);
    check({tg, ".idle.act"}, 32'(bus.ROUND_ACT), 32'd0);
    check({tg, ".idle.res"}, 32'(bus.RESULT), 32'd0);
  endtask

  task automatic reset_mid(bit in_rep);
    clear_stim();
    key     = 8'h5A;
    my_v[0] = 1'b1;
    my_a[0] = in_rep ? key : ~key;
    @(negedge CLK);
    idle_in();
    bus.START = 1'b1;
    bus.KEY   = key;
    @(negedge CLK);
    bus.START = 1'b0;
    drive(0);
    bus.START = 1'b0;
    @(negedge CLK);
    idle_in();
    @(negedge CLK);
    if (in_rep)
      check("rst.pre.res", 32'(bus.RESULT), 32'd1);
    else
      check("rst.pre.mlk", 32'(bus.MY_LOCK), 32'd1);
    #2 RST = 1'b0;
    #1 chk_state("rst.async", 0, 2'b00, 0, 0, 0);
    @(negedge CLK);
    RST = 1'b1;
    for (int i = 0; i < 6; i++) begin
      bus.MY_VLD = 1'($urandom);
      bus.EN_VLD = 1'($urandom);
      bus.MY_ANS = key;
      bus.EN_ANS = key;
      @(negedge CLK);
      check("rst.after.res", 32'(bus.RESULT), 32'd0);
      check("rst.after.act", 32'(bus.ROUND_ACT), 32'd0);
    end
    idle_in();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    n_cmp = 0;
    n_bad = 0;
    RST   = 1'b0;
    idle_in();
    bus.KEY    = '0;
    bus.MY_ANS = '0;
    bus.EN_ANS = '0;
    repeat (2) @(negedge CLK);
    chk_state("reset", 0, 2'b00, 0, 0, 0);
    RST = 1'b1;

    clear_stim(); key = 8'h23;
    my_v[3] = 1; my_a[3] = 8'h23;
    run_round("first");

    clear_stim(); key = 8'h15;
    en_v[0] = 1; en_a[0] = 8'h14;
    en_v[1] = 1; en_a[1] = 8'h15;
    my_v[2] = 1; my_a[2] = 8'h15;
    run_round("enlock");

    clear_stim(); key = 8'h0F;
    my_v[1] = 1; my_a[1] = 8'h0F;
    en_v[1] = 1; en_a[1] = 8'h0F;
    run_round("tie");

    clear_stim(); key = 8'h0F;
    my_v[0] = 1; my_a[0] = 8'h0F;
    en_v[0] = 1; en_a[0] = 8'h8F;
    run_round("okbad");

    clear_stim(); key = 8'h77;
    run_round("timeout");

    clear_stim(); key = 8'h77;
    en_v[TO] = 1; en_a[TO] = 8'h77;
    run_round("lastcyc");

    clear_stim(); key = 8'h80;
    my_v[1] = 1; my_a[1] = 8'h00;
    en_v[3] = 1; en_a[3] = 8'h81;
    run_round("bothbad");

    reset_mid(1'b0);
    reset_mid(1'b1);

    for (int r = 0; r < 150; r++) begin
      clear_stim();
      key = 8'($urandom);
      for (int k = 0; k <= TO; k++) begin
        my_v[k] = ($urandom % 5) == 0;
        en_v[k] = ($urandom % 5) == 0;
        my_a[k] = ($urandom % 3 == 0) ? key :
                  key ^ 8'(1 << ($urandom % 8));
        en_a[k] = ($urandom % 3 == 0) ? key :
                  key ^ 8'(1 << ($urandom % 8));
      end
      run_round("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
